// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encoding, ALU op codes and seed constant for the Fibonacci sequencer
package fib_pkg;

  // Sequencer states; the numeric encoding is visible on debug taps, so it is pinned here.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_ADD   = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5
  } fib_state_e;

  // ALU operation codes understood by the datapath.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;

  // Both seed registers r0 and r1 are loaded with this immediate.
  localparam logic [15:0] FIB_SEED = 16'd1;

  // True for every state in which the sequencer is actively issuing work.
  function automatic logic state_is_busy(input fib_state_e st);
    return (st == ST_LOAD0) || (st == ST_LOAD1) || (st == ST_ADD) || (st == ST_STORE);
  endfunction

endpackage

// File: rtl/fib_op_decode.sv
// rtl/fib_op_decode.sv - maps sequencer state and counters onto register file, ALU and memory controls
module fib_op_decode
  import fib_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_AW    = 4,
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0
) (
  input  fib_state_e          state,
  input  logic [REG_AW-1:0]   k,
  input  logic [REG_AW-1:0]   s,
  input  logic                stall,
  output logic [REG_AW-1:0]   ra_addr,
  output logic [REG_AW-1:0]   rb_addr,
  output logic [REG_AW-1:0]   wr_addr,
  output logic                wr_en,
  output logic                imm_sel,
  output logic [15:0]         imm,
  output logic [1:0]          alu_op,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic                busy,
  output logic                done
);

  localparam logic [REG_AW-1:0] ONE    = REG_AW'(1);
  localparam logic [REG_AW-1:0] TWO    = REG_AW'(2);
  localparam logic [REG_AW-1:0] LAST   = REG_AW'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  // Write strobes before the stall mask; addresses are never masked so they hold through a stall.
  logic wr_pre;
  logic mem_pre;

  // Moore decode of the micro-operation issued in the current state.
  always_comb begin
    ra_addr  = '0;
    rb_addr  = '0;
    wr_addr  = '0;
    wr_pre   = 1'b0;
    imm_sel  = 1'b0;
    imm      = '0;
    alu_op   = ALU_ADD;
    mem_addr = '0;
    mem_pre  = 1'b0;
    unique case (state)
      ST_LOAD0: begin
        wr_addr = '0;
        imm_sel = 1'b1;
        imm     = FIB_SEED;
        wr_pre  = 1'b1;
      end
      ST_LOAD1: begin
        wr_addr = ONE;
        imm_sel = 1'b1;
        imm     = FIB_SEED;
        wr_pre  = 1'b1;
      end
      ST_ADD: begin
        ra_addr = k - ONE;
        rb_addr = k - TWO;
        wr_addr = k;
        alu_op  = ALU_ADD;
        wr_pre  = 1'b1;
      end
      ST_STORE: begin
        // Address wraps modulo 2^ADDR_W so a base near the top of memory rolls over to 0.
        ra_addr  = s;
        mem_addr = BASE_A + ADDR_W'(s);
        mem_pre  = 1'b1;
      end
      ST_DONE: begin
        // Parked NOP: r(last) = r(last) | r(last), with the write itself suppressed.
        ra_addr = LAST;
        rb_addr = LAST;
        wr_addr = LAST;
        alu_op  = ALU_OR;
      end
      default: begin
      end
    endcase
  end

  // A stalled cycle must not commit anything to the register file or memory.
  assign wr_en  = wr_pre & ~stall;
  assign mem_we = mem_pre & ~stall;

  assign busy = state_is_busy(state);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/fib_seq_controller.sv
// rtl/fib_seq_controller.sv - Fibonacci demo sequencer: seed, accumulate and store the register file
module fib_seq_controller
  import fib_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_AW    = 4,
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                stall,
  output logic [REG_AW-1:0]   ra_addr,
  output logic [REG_AW-1:0]   rb_addr,
  output logic [REG_AW-1:0]   wr_addr,
  output logic                wr_en,
  output logic                imm_sel,
  output logic [15:0]         imm,
  output logic [1:0]          alu_op,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic                busy,
  output logic                done
);

  localparam logic [REG_AW-1:0] LAST    = REG_AW'(NUM_REGS - 1);
  localparam logic [REG_AW-1:0] K_FIRST = REG_AW'(2);
  localparam logic [REG_AW-1:0] ONE     = REG_AW'(1);

  fib_state_e        state;
  logic [REG_AW-1:0] k;
  logic [REG_AW-1:0] s;

  // Sequencer: one micro-op per cycle, frozen by stall, restartable only from IDLE or DONE.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      k     <= K_FIRST;
      s     <= '0;
    end else if (!stall) begin
      unique case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD0;
        end
        ST_LOAD0: begin
          state <= ST_LOAD1;
        end
        ST_LOAD1: begin
          state <= ST_ADD;
          k     <= K_FIRST;
        end
        ST_ADD: begin
          if (k == LAST) begin
            state <= ST_STORE;
            s     <= '0;
          end else begin
            k <= k + ONE;
          end
        end
        ST_STORE: begin
          if (s == LAST) state <= ST_DONE;
          else           s     <= s + ONE;
        end
        ST_DONE: begin
          if (start) state <= ST_LOAD0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  fib_op_decode #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_decode (
    .state   (state),
    .k       (k),
    .s       (s),
    .stall   (stall),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .imm_sel (imm_sel),
    .imm     (imm),
    .alu_op  (alu_op),
    .mem_addr(mem_addr),
    .mem_we  (mem_we),
    .busy    (busy),
    .done    (done)
  );

endmodule

// File: doc/fib_seq_controller.md
Name: fib_seq_controller

Overview:
- Sequencer for the 16-entry register file and ALU datapath of the Fibonacci demo.
- On `start` it issues one micro-operation per cycle:
  - load immediate 1 into r0 and r1;
  - compute rK = rK-1 + rK-2 for K = 2..NUM_REGS-1;
  - store r0..r(NUM_REGS-1) to data memory at BASE_ADDR onward.
- It then parks on a NOP and raises `done`.
- It sits between the top-level control and the register file, ALU and memory port.

Parameters:
- NUM_REGS, 16, number of registers filled and stored (3..16).
- REG_AW, 4, register address width.
- ADDR_W, 15, memory address width.
- BASE_ADDR, 0, first memory word written in the store phase.

Ports:
- clk, input, 1, system clock, rising edge.
- clr, input, 1, synchronous active-high reset.
- start, input, 1, begin a run; sampled only in IDLE or DONE.
- stall, input, 1, freeze the sequencer this cycle (memory or ALU not ready).
- ra_addr, output, REG_AW, register file read port A address.
- rb_addr, output, REG_AW, register file read port B address.
- wr_addr, output, REG_AW, register file write address.
- wr_en, output, 1, register file write enable.
- imm_sel, output, 1, 1 selects the immediate as write data; 0 selects the ALU result.
- imm, output, 16, immediate value.
- alu_op, output, 2, ALU operation: 00 = ADD, 01 = OR.
- mem_addr, output, ADDR_W, data memory address.
- mem_we, output, 1, data memory write enable; write data is read port A.
- busy, output, 1, high from LOAD0 through STORE.
- done, output, 1, high while in DONE.

Behaviour:
- States: IDLE, LOAD0, LOAD1, ADD, STORE, DONE.
- Counters: `k` (REG_AW bits) for ADD; `s` (REG_AW bits) for STORE.
- Outputs are Moore, decoded from the registered state and counters. There is no combinational path from start or stall, except that stall masks wr_en and mem_we.
- Reset:
  - clr=1 at an edge forces IDLE with k=2 and s=0, regardless of state. This applies mid-run: an interrupted run writes nothing further.
  - Values in IDLE: all addresses 0, wr_en=0, mem_we=0, imm_sel=0, imm=0, alu_op=ADD, busy=0, done=0.
- IDLE: if start=1 at an edge, go to LOAD0. Latency is 1 cycle.
- LOAD0: wr_addr=0, imm_sel=1, imm=1, wr_en=1. Next state is LOAD1.
- LOAD1: wr_addr=1, imm_sel=1, imm=1, wr_en=1. Next state is ADD, with k=2.
- ADD:
  - Outputs: ra_addr=k-1, rb_addr=k-2, wr_addr=k, alu_op=ADD, imm_sel=0, wr_en=1.
  - If k==NUM_REGS-1, go to STORE with s=0; otherwise k<=k+1.
- STORE:
  - Outputs: ra_addr=s, mem_addr=BASE_ADDR+s (zero-extended, modulo 2^ADDR_W), mem_we=1, wr_en=0.
  - If s==NUM_REGS-1, go to DONE; otherwise s<=s+1.
- DONE:
  - Issues the NOP r15=r15|r15: ra, rb and wr addresses all NUM_REGS-1, alu_op=OR, wr_en=0, mem_we=0.
  - done=1, busy=0.
  - start=1 at an edge goes to LOAD0, giving a full rerun.
- stall=1:
  - state, k and s hold;
  - wr_en and mem_we are forced 0 that cycle;
  - all address outputs hold their values.
  - A stall on the final ADD or final STORE cycle delays the transition; nothing is skipped or duplicated.
- start is ignored while busy=1.
- clr and start asserted together: clr wins, and the block stays in IDLE.
- clr and stall asserted together: clr wins.
- Cycle counts (no stalls, NUM_REGS=16):
  - 2 LOAD + 14 ADD + 16 STORE = 32 busy cycles;
  - done rises on the 33rd edge after start is sampled.
- Arithmetic: counter compares are exact equality at REG_AW width, with no wrap. The datapath owns 16-bit ALU overflow; the controller does not observe data.

Decomposition:
- Shared package `fib_pkg` holds:
  - the state encoding constants (IDLE=0, LOAD0=1, LOAD1=2, ADD=3, STORE=4, DONE=5, 3-bit);
  - the ALU op codes (ADD=2'b00, OR=2'b01);
  - the immediate constant FIB_SEED=16'd1.
- One natural sub-module, `fib_op_decode`: combinational mapping from (state, k, s, stall) to the datapath control outputs. The FSM and counters stay in the top module.

Test Plan:
- Reset and idle: hold clr=1 for 2 cycles with start=1. Required: IDLE outputs as listed, busy=0, done=0, no wr_en or mem_we pulses.
- Full run:
  - Stimulus: one-cycle start pulse, bench models the register file and ALU.
  - Required register contents: r0..r15 = 1,1,2,3,5,8,13,21,34,55,89,144,233,377,610,987.
  - Required memory: mem[0..15] holds the same values.
  - Required timing: done=1 exactly 33 edges after start.
- Stall coverage:
  - Stimulus: stall=1 for 3 cycles at k=7, and again on the final STORE (s=15).
  - Required: same final contents, done delayed by exactly 6 cycles, no duplicate or missing writes (write count 16, store count 16).
- Mid-run reset: assert clr during STORE at s=5. Required: IDLE on the next edge; mem[6..15] are never written.
- Start while busy and rerun:
  - Pulse start at ADD k=4: required to have no effect.
  - After done, pulse start again: required to rerun identically.
  - Assert start and clr together: required to stay in IDLE.
- Parameter corner: NUM_REGS=3, BASE_ADDR=32766.
  - Required: r2=2.
  - Required: stores to 32766, 32767, then 0 (address wraps).
  - Required: done after 2 LOAD + 1 ADD + 3 STORE = 6 busy cycles.
